// File: rtl/bsg_level_shift_iso_seq_if.sv
// ---------------------------------------------------------------------------
// bsg_level_shift_iso_seq_if : data/control bundle of the isolation sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bsg_level_shift_iso_seq_if #(
  parameter int width_p = 32,
  parameter int els_p   = 2
);
  logic                     wake_req_i;
  logic [els_p-1:0]         en_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p*width_p-1:0] data_o;
  logic                     iso_o;
  logic                     ready_o;
  logic                     settling_o;

  modport master (
    output wake_req_i, en_i, data_i,
    input  data_o, iso_o, ready_o, settling_o
  );

  modport slave (
    input  wake_req_i, en_i, data_i,
    output data_o, iso_o, ready_o, settling_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_level_shift_iso_seq.sv
// ---------------------------------------------------------------------------
// bsg_level_shift_iso_seq : registered, clamped, wake/sleep-sequenced source
//                           side of a power-domain crossing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_level_shift_iso_seq #(
  parameter int   width_p         = 32,
  parameter int   els_p           = 2,
  parameter int   settle_cycles_p = 4,
  parameter logic clamp_val_p     = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bsg_level_shift_iso_seq_if.slave    bus_if
);

  localparam int cnt_width_lp  = $clog2(settle_cycles_p + 1);
  localparam int data_width_lp = els_p * width_p;
  localparam logic [cnt_width_lp-1:0]  cnt_load_lp = cnt_width_lp'(settle_cycles_p - 1);
  localparam logic [data_width_lp-1:0] clamp_lp    = {data_width_lp{clamp_val_p}};

  typedef enum logic [1:0] {
    e_iso   = 2'd0,
    e_wake  = 2'd1,
    e_on    = 2'd2,
    e_sleep = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [data_width_lp-1:0]  data_q, data_d;
  logic [data_width_lp-1:0]  gated_data;

  // Disabled channels drive zero, not the clamp value.
  for (genvar j = 0; j < els_p; j++) begin : g_chan
    assign gated_data[j*width_p +: width_p] =
      bus_if.en_i[j] ? bus_if.data_i[j*width_p +: width_p] : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_iso;
      cnt_q   <= '0;
      data_q  <= clamp_lp;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      e_iso: begin
        data_d = clamp_lp;
        if (bus_if.wake_req_i) begin
          state_d = e_wake;
          cnt_d   = cnt_load_lp;
        end
      end
      e_wake: begin
        data_d = clamp_lp;
        if (!bus_if.wake_req_i) begin
          state_d = e_iso;
        end else if (cnt_q == '0) begin
          state_d = e_on;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      e_on: begin
        data_d = gated_data;
        if (!bus_if.wake_req_i) begin
          state_d = e_sleep;
          cnt_d   = cnt_load_lp;
        end
      end
      e_sleep: begin
        // Sleep cannot be aborted; data holds until the clamp re-engages.
        if (cnt_q == '0) begin
          state_d = e_iso;
          data_d  = clamp_lp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = e_iso;
        cnt_d   = '0;
        data_d  = clamp_lp;
      end
    endcase
  end

  assign bus_if.data_o     = data_q;
  assign bus_if.iso_o      = (state_q != e_on);
  assign bus_if.ready_o    = (state_q == e_on);
  assign bus_if.settling_o = (state_q == e_wake) || (state_q == e_sleep);

endmodule

`default_nettype wire

// File: tb/tb_bsg_level_shift_iso_seq.sv
// ---------------------------------------------------------------------------
// tb_bsg_level_shift_iso_seq : self-checking bench for the isolation sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bsg_level_shift_iso_seq;

  localparam int W = 32;
  localparam int E = 2;
  localparam int S = 4;
  localparam logic [63:0] CLAMP = 64'hFFFF_FFFF_FFFF_FFFF;
  // {iso, ready, settling}
  localparam logic [2:0] ST_ISO    = 3'b100;
  localparam logic [2:0] ST_SETTLE = 3'b101;
  localparam logic [2:0] ST_ON     = 3'b010;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];

  bsg_level_shift_iso_seq_if #(.width_p(W), .els_p(E)) bus ();

  bsg_level_shift_iso_seq #(
    .width_p(W), .els_p(E), .settle_cycles_p(S), .clamp_val_p(1'b1)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [2:0] status = {bus.iso_o, bus.ready_o, bus.settling_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.data_o !== CLAMP) begin
      errors++; $display("FAIL reset_data: got %h want %h", bus.data_o, CLAMP);
    end
    checks++;
    if (status !== ST_ISO) begin
      errors++; $display("FAIL reset_status: got %b want %b", status, ST_ISO);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (status !== ST_ISO || bus.data_o !== CLAMP) begin
      errors++; $display("FAIL post_reset_idle: got %b/%h want %b/%h", status, bus.data_o, ST_ISO, CLAMP);
    end
  endtask

  // From ISO: raise wake, expect S settling cycles then ON.
  task automatic test_wake();
    bus.wake_req_i = 1'b1;
    for (int i = 1; i <= S; i++) begin
      bus.en_i   = E'($urandom);
      bus.data_i = {$urandom, $urandom};
      tick();
      checks++;
      if (status !== ST_SETTLE || bus.data_o !== CLAMP) begin
        errors++; $display("FAIL wake_cycle%0d: got %b/%h want %b/%h", i, status, bus.data_o, ST_SETTLE, CLAMP);
      end
    end
    tick();
    checks++;
    if (status !== ST_ON || bus.data_o !== CLAMP) begin
      errors++; $display("FAIL wake_on: got %b/%h want %b/%h", status, bus.data_o, ST_ON, CLAMP);
    end
  endtask

  task automatic drive_on(input logic [63:0] d, input logic [1:0] en);
    logic [63:0] e;
    bus.data_i = d;
    bus.en_i   = en;
    e = {en[1] ? d[63:32] : 32'h0, en[0] ? d[31:0] : 32'h0};
    exp_q.push_back(e);
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      if (bus.data_o !== e) begin
        errors++; $display("FAIL on_data: got %h want %h", bus.data_o, e);
      end
    end
  endtask

  task automatic test_first_data();
    drive_on(64'hDEADBEEF_12345678, 2'b11);
  endtask

  task automatic test_gating();
    drive_on(64'hFFFFFFFF_AAAAAAAA, 2'b01);
    drive_on(64'h13572468_FFFFFFFF, 2'b10);
    drive_on(64'hFFFFFFFF_FFFFFFFF, 2'b00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive_on({$urandom, $urandom}, 2'($urandom));
    checks++;
    if (status !== ST_ON) begin
      errors++; $display("FAIL b2b_status: got %b want %b", status, ST_ON);
    end
  endtask

  task automatic test_sleep();
    drive_on(64'h11111111_22222222, 2'b11);
    bus.wake_req_i = 1'b0;
    for (int i = 1; i <= S; i++) begin
      tick();
      bus.data_i = {$urandom, $urandom};
      bus.en_i   = 2'($urandom);
      checks++;
      if (status !== ST_SETTLE || bus.data_o !== 64'h11111111_22222222) begin
        errors++; $display("FAIL sleep_hold%0d: got %b/%h want %b/%h", i, status, bus.data_o, ST_SETTLE, 64'h11111111_22222222);
      end
    end
    tick();
    checks++;
    if (status !== ST_ISO || bus.data_o !== CLAMP) begin
      errors++; $display("FAIL sleep_to_iso: got %b/%h want %b/%h", status, bus.data_o, ST_ISO, CLAMP);
    end
  endtask

  task automatic test_abort();
    bus.wake_req_i = 1'b1;
    tick();
    tick();
    checks++;
    if (status !== ST_SETTLE) begin
      errors++; $display("FAIL abort_wake: got %b want %b", status, ST_SETTLE);
    end
    bus.wake_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.data_i = {$urandom, $urandom};
      bus.en_i   = 2'($urandom);
      tick();
      checks++;
      if (status !== ST_ISO || bus.data_o !== CLAMP) begin
        errors++; $display("FAIL abort_iso%0d: got %b/%h want %b/%h", i, status, bus.data_o, ST_ISO, CLAMP);
      end
    end
  endtask

  task automatic test_rewake();
    test_wake();
    drive_on(64'hCAFEF00D_0BADC0DE, 2'b11);
    bus.wake_req_i = 1'b0;
    tick();
    bus.wake_req_i = 1'b1;
    for (int i = 2; i <= S; i++) begin
      tick();
      checks++;
      if (status !== ST_SETTLE || bus.data_o !== 64'hCAFEF00D_0BADC0DE) begin
        errors++; $display("FAIL rewake_sleep%0d: got %b/%h", i, status, bus.data_o);
      end
    end
    tick();
    checks++;
    if (status !== ST_ISO || bus.data_o !== CLAMP) begin
      errors++; $display("FAIL rewake_iso: got %b/%h want %b/%h", status, bus.data_o, ST_ISO, CLAMP);
    end
    for (int i = 1; i <= S; i++) begin
      tick();
      checks++;
      if (status !== ST_SETTLE || bus.data_o !== CLAMP) begin
        errors++; $display("FAIL rewake_wake%0d: got %b/%h want %b/%h", i, status, bus.data_o, ST_SETTLE, CLAMP);
      end
    end
    tick();
    checks++;
    if (status !== ST_ON) begin
      errors++; $display("FAIL rewake_on: got %b want %b", status, ST_ON);
    end
  endtask

  task automatic test_reset_mid();
    drive_on(64'h0F0F0F0F_F0F0F0F0, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (status !== ST_ISO || bus.data_o !== CLAMP) begin
      errors++; $display("FAIL reset_mid: got %b/%h want %b/%h", status, bus.data_o, ST_ISO, CLAMP);
    end
    bus.wake_req_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (status !== ST_ISO || bus.data_o !== CLAMP) begin
      errors++; $display("FAIL reset_mid_after: got %b/%h want %b/%h", status, bus.data_o, ST_ISO, CLAMP);
    end
    test_wake();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.wake_req_i = 1'b0;
    bus.en_i       = '0;
    bus.data_i     = '0;
    test_reset();
    test_wake();
    test_first_data();
    test_gating();
    test_back_to_back();
    test_sleep();
    test_abort();
    test_rewake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
